dot_product_ctrl: RTL and testbench

//   Sequencer and accumulator for an unsigned vector dot product: sum(a[i]*b[i]), i=0..len-1.

---
 rtl/dot_product_ctrl.sv | 125 ++++++++++++
 tb/tb_dot_product_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dot_product_ctrl.sv
// Sequencer/accumulator for an unsigned dot product over two synchronous-read operand RAMs.
// Optional saturating accumulation and overflow flag: define DOTP_SAT_EN.
module dot_product_ctrl #(
  parameter int DW    = 10,
  parameter int AW    = 5,
  parameter int ACC_W = 22
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             start,
  input  logic [AW:0]      len,
  output logic             rd_en,
  output logic [AW-1:0]    addr,
  input  logic [DW-1:0]    a_data,
  input  logic [DW-1:0]    b_data,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [AW:0]        len_q;
  logic [AW-1:0]      addr_q;
  logic               vld;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [2*DW-1:0]    prod;
  logic               last;

  assign prod  = a_data * b_data;
  assign last  = ({1'b0, addr_q} == len_q - (AW+1)'(1));
  assign rd_en = (state == FETCH);
  assign busy  = (state == FETCH) || (state == DRAIN);
  assign done  = (state == DONE);
  assign addr  = addr_q;

`ifdef DOTP_SAT_EN
  logic             sticky, sticky_nxt;
  logic [ACC_W:0]   sum;

  // Carry out of the widened sum marks overflow; the clamp then holds because
  // any further nonzero product carries again.
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod);

  always_comb begin
    acc_nxt    = acc;
    sticky_nxt = sticky;
    if (vld) begin
      if (sum[ACC_W]) begin
        acc_nxt    = '1;
        sticky_nxt = 1'b1;
      end else begin
        acc_nxt    = sum[ACC_W-1:0];
      end
    end
  end
`else
  always_comb begin
    acc_nxt = acc;
    if (vld) acc_nxt = acc + ACC_W'(prod);
  end
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : FETCH;
      FETCH:   if (last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // result is loaded on entry to DONE so it is already valid while done is high.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state  <= IDLE;
      len_q  <= '0;
      addr_q <= '0;
      vld    <= 1'b0;
      acc    <= '0;
      result <= '0;
`ifdef DOTP_SAT_EN
      sticky <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      vld   <= rd_en;
      acc   <= acc_nxt;
`ifdef DOTP_SAT_EN
      sticky <= sticky_nxt;
`endif
      case (state)
        IDLE: if (start) begin
          acc    <= '0;
          addr_q <= '0;
          len_q  <= len;
`ifdef DOTP_SAT_EN
          sticky <= 1'b0;
`endif
          if (len == '0) begin
            result <= '0;
`ifdef DOTP_SAT_EN
            ovf    <= 1'b0;
`endif
          end
        end
        FETCH: if (!last) addr_q <= addr_q + AW'(1);
        DRAIN: begin
          result <= acc_nxt;
`ifdef DOTP_SAT_EN
          ovf    <= sticky_nxt;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: constant vector table, hand sequences, random runs vs model.
module tb_dot_product_ctrl;
  localparam int DW = 10, AW = 5, ACC_W = 22, N = 32;
`ifdef DOTP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             CLOCK = 1'b0, RESET = 1'b1, start = 1'b0;
  logic [AW:0]      len = '0;
  logic             rd_en, busy, done, ovf;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    a_data = '0, b_data = '0;
  logic [ACC_W-1:0] result;

  dot_product_ctrl #(.DW(DW), .AW(AW), .ACC_W(ACC_W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .start(start), .len(len), .rd_en(rd_en), .addr(addr),
    .a_data(a_data), .b_data(b_data), .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  always #5 CLOCK = ~CLOCK;

  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];
  always @(posedge CLOCK) if (rd_en) begin
    a_data <= mem_a[addr];
    b_data <= mem_b[addr];
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < N; i++) begin
      case (pat)
        0: begin mem_a[i] = (i < 3) ? DW'(3 + i) : '0; mem_b[i] = (i < 3) ? DW'(6 + i) : '0; end
        1: begin mem_a[i] = 10'd1023; mem_b[i] = 10'd1023; end
        2: begin mem_a[i] = DW'(i); mem_b[i] = 10'd1; end
        default: begin
          mem_a[i] = (pat == 4) ? DW'($urandom_range(900, 1023)) : DW'($urandom);
          mem_b[i] = (pat == 4) ? DW'($urandom_range(900, 1023)) : DW'($urandom);
        end
      endcase
    end
  endtask

  // Reference: the exact sum, then wrapped or clamped; sums of nonnegative terms are monotonic.
  task automatic model(input int ln, output logic [ACC_W-1:0] res, output logic o);
    longint s = 0;
    longint mx = (longint'(1) << ACC_W) - 1;
    for (int i = 0; i < ln; i++) s += longint'(mem_a[i]) * longint'(mem_b[i]);
    if (SAT) begin
      o   = (s > mx);
      res = (s > mx) ? ACC_W'(mx) : ACC_W'(s);
    end else begin
      o   = 1'b0;
      res = ACC_W'(s % (mx + 1));
    end
  endtask

  task automatic run(input int ln, input bit mid, output logic [ACC_W-1:0] res, output logic o);
    int cyc = 0, done_cyc = -1, nrd = 0, exp_addr = 0, bad_addr = 0, bad_busy = 0, bad_idle = 0;
    res = '0; o = 1'b0;
    @(negedge CLOCK); start = 1'b1; len = (AW+1)'(ln);
    @(posedge CLOCK);
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge CLOCK); cyc++;
      start = mid && (cyc >= 2 && cyc <= 4);
      len = (AW+1)'($urandom);
      if (busy !== (ln != 0 && cyc <= ln + 1)) bad_busy++;
      if (rd_en === 1'b1) begin
        if (addr !== AW'(exp_addr) || exp_addr >= ln) bad_addr++;
        exp_addr++; nrd++;
      end
      if (done === 1'b1) begin
        done_cyc = cyc; res = result; o = ovf;
        if (mid) start = 1'b1;
      end
    end
    chk("latency", done_cyc, (ln == 0) ? 1 : ln + 2);
    chk("rd_count", nrd, ln);
    chk("addr_seq", bad_addr, 0);
    chk("busy", bad_busy, 0);
    if (!mid) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge CLOCK); start = 1'b0;
        if (done !== 1'b0 || busy !== 1'b0 || result !== res) bad_idle++;
      end
      chk("idle_hold", bad_idle, 0);
    end
  endtask

  typedef struct {int ln; int pat; logic [ACC_W-1:0] res; logic ovf;} vec_t;
  vec_t tbl [7];

  initial begin
    logic [ACC_W-1:0] r, mr;
    logic o, mo;
    int bad;
    tbl[0] = '{3, 0, 22'd86, 1'b0};
    tbl[1] = '{0, 0, 22'd0, 1'b0};
    tbl[2] = '{5, 1, SAT ? 22'd4194303 : 22'd1038341, SAT};
    tbl[3] = '{32, 2, 22'd496, 1'b0};
    tbl[4] = '{1, 0, 22'd18, 1'b0};
    tbl[5] = '{2, 0, 22'd46, 1'b0};
    tbl[6] = '{32, 1, SAT ? 22'd4194303 : 22'd4128800, SAT};

    repeat (3) @(negedge CLOCK);
    chk("rst_outs", {rd_en, busy, done, ovf, addr}, 0);
    chk("rst_result", result, 0);
    RESET = 1'b0;

    foreach (tbl[i]) begin
      fill(tbl[i].pat);
      run(tbl[i].ln, 1'b0, r, o);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].res);
      chk($sformatf("tbl%0d_ovf", i), o, tbl[i].ovf);
    end

    // Starts while busy and in DONE are ignored; a start the next cycle runs.
    fill(0);
    run(3, 1'b1, r, o);
    chk("ignored_starts", r, 86);
    run(3, 1'b0, r, o);
    chk("back_to_back", r, 86);

    // Reset on cycle 3 aborts the run without a done pulse.
    fill(2);
    @(negedge CLOCK); start = 1'b1; len = 6'd3;
    @(posedge CLOCK);
    @(negedge CLOCK); start = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK); RESET = 1'b1;
    @(negedge CLOCK);
    chk("abort_outs", {rd_en, busy, done, ovf, addr}, 0);
    chk("abort_result", result, 0);
    RESET = 1'b0;
    bad = 0;
    repeat (6) begin @(negedge CLOCK); if (done !== 1'b0 || busy !== 1'b0) bad++; end
    chk("abort_quiet", bad, 0);
    fill(0);
    run(3, 1'b0, r, o);
    chk("after_abort", r, 86);

    for (int t = 0; t < 25; t++) begin
      int ln;
      ln = (t % 5 == 0) ? 32 : $urandom_range(0, 32);
      fill((t % 3 == 0) ? 4 : 3);
      model(ln, mr, mo);
      run(ln, 1'b0, r, o);
      chk($sformatf("rand%0d_result", t), r, mr);
      chk($sformatf("rand%0d_ovf", t), o, mo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
